regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file for the pipelined MIPS datapath. It supersedes the fixed 32x32, two-read-port register file. New behaviour over that block:
- synchronous registered reads on the rising edge, with write-to-read bypass;
- optional hardwired zero register;
- a post-reset clear sequencer that zeroes every entry, so no preload file is needed.

It sits between the ID stage (read addresses) and the WB stage (write port).

## Interface
Parameters:
- DATA_W, 32, width of each register
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- regWrite  input  1  write enable
- writeReg  input  ADDR_W  write address
- writeData  input  DATA_W  write data
- readAddr  input  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- readData  output  NUM_RD*DATA_W  packed registered read data; port i at bits [i*DATA_W +: DATA_W]
- busy  output  1  high while the clear sequence runs

## Operation
- Two-state control FSM:
  - CLEAR: clr_ptr walks 0..DEPTH-1 and writes 0 to entry clr_ptr each cycle. On the cycle clr_ptr==DEPTH-1 the FSM moves to RUN.
  - RUN: normal operation. The FSM leaves RUN only through reset.
- In CLEAR:
  - regWrite is ignored; no user write is queued.
  - All readData ports return 0.
- Write in RUN: when regWrite=1, mem[writeReg] <= writeData at the rising edge.
  - If ZERO_REG=1 and writeReg==0, the write is dropped.
- Read in RUN: each port i registers a value at every rising edge:
  - 0 if ZERO_REG=1 and readAddr_i==0;
  - else writeData if regWrite=1 and writeReg==readAddr_i (bypass, same edge);
  - else mem[readAddr_i].
- Several ports may read the same address; each returns the same value.
- Width rules: no arithmetic on data. clr_ptr is ADDR_W bits and wrap is never reached, because the FSM exits at DEPTH-1.

## Timing
- While rst_n=0 at a rising edge: state=CLEAR, clr_ptr=0, busy=1, every readData lane=0. Memory contents are undefined until the clear completes.
- After rst_n rises, the clear takes exactly DEPTH cycles. busy falls at the edge after the final clear write (edge DEPTH counted from the first edge with rst_n=1). The first write is accepted at that same edge.
- Read latency is 1 cycle: the address presented before edge k gives data valid after edge k.
- Write-to-read latency:
  - same edge: bypass value;
  - later edges: stored value.
- Reset asserted mid-clear or mid-RUN takes effect at the next edge. The clear then restarts from entry 0.
- A regWrite asserted on the edge where busy falls is accepted. One asserted while busy=1 is lost, and the caller must hold it off.

## Structure
- Package regfile_pkg holds:
  - the state enum {CLEAR, RUN};
  - default DATA_W/ADDR_W/NUM_RD constants;
  - a function returning DEPTH from ADDR_W.
- One sub-module, regfile_clear_seq, contains the FSM, clr_ptr and busy. It outputs clr_we/clr_addr to the top level, which muxes them onto the memory write port.
- Storage and the per-port read/bypass logic stay in the top level. The read ports are built with a generate loop over NUM_RD.

## Test plan
- Reset and clear: hold rst_n=0 for 3 cycles, then release; busy stays 1 for 32 cycles then falls; reading every address 0..31 returns 0x00000000.
- Write then read: write 0xDEADBEEF to reg 7; reading port 0 at reg 7 one cycle later gives 0xDEADBEEF.
- Bypass: regWrite=1, writeReg=5, writeData=0x12345678, and readAddr for ports 0 and 1 both 5 on the same edge; both readData lanes show 0x12345678 after that edge.
- Zero register: write 0xFFFFFFFF to reg 0; read reg 0 returns 0, including on the bypass edge. With ZERO_REG=0 the same test returns 0xFFFFFFFF.
- Write during clear: assert regWrite to reg 3 with 0xAA while busy=1; after busy falls, reg 3 reads 0.
- Reset mid-operation: fill reg 9 with 0x55, assert rst_n=0 for 1 cycle, release; busy=1 for 32 cycles, then reg 9 reads 0. Repeat with NUM_RD=4, ADDR_W=3 (busy for 8 cycles).

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-read-port register file.
// DEPTH is always derived from the address width through depth_of().
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every entry once writing zero, then
// parks in RUN until the next reset. State is exported for observation.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_last,
    output logic              busy,
    output rf_state_t         state
);

    localparam int DEPTH = depth_of(ADDR_W);

    rf_state_t         state_nxt;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] clr_ptr_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    // The exit happens on the last entry, so clr_ptr never needs to wrap.
    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        clr_we      = 1'b0;
        clr_last    = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                    clr_last    = 1'b1;
                    state_nxt   = RUN;
                    clr_ptr_nxt = '0;
                end else begin
                    clr_ptr_nxt = clr_ptr + 1'b1;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    assign clr_addr = clr_ptr;
    assign busy     = (state == CLEAR);

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD registered read ports with same-edge
// write bypass, optional hardwired zero entry, and a self-clear after reset.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     regWrite,
    input  logic [ADDR_W-1:0]        writeReg,
    input  logic [DATA_W-1:0]        writeData,
    input  logic [NUM_RD*ADDR_W-1:0] readAddr,
    output logic [NUM_RD*DATA_W-1:0] readData,
    output logic                     busy
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_last;
    rf_state_t         state;
    logic              user_we;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clr_last (clr_last),
        .busy     (busy),
        .state    (state)
    );

    // User writes open on the final clear edge, which is also when busy drops.
    assign user_we = rst_n && regWrite && ((state == RUN) || clr_last) &&
                     !((ZERO_REG != 0) && (writeReg == '0));

    // Per-entry write mux: a user write overrides the clear on a shared edge.
    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (user_we && (writeReg == ADDR_W'(e))) begin
                mem[e] <= writeData;
            end else if (clr_we && (clr_addr == ADDR_W'(e))) begin
                mem[e] <= '0;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_q;

        assign ra = readAddr[i*ADDR_W +: ADDR_W];

        always_ff @(posedge clk) begin
            if (!rst_n || (state == CLEAR)) begin
                rd_q <= '0;
            end else if ((ZERO_REG != 0) && (ra == '0)) begin
                rd_q <= '0;
            end else if (regWrite && (writeReg == ra)) begin
                rd_q <= writeData;
            end else begin
                rd_q <= mem[ra];
            end
        end

        assign readData[i*DATA_W +: DATA_W] = rd_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default, ZERO_REG=0, and NUM_RD=4/ADDR_W=3
// instances, each exercised by its own scenario tasks.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // default instance
    logic        rst_n, reg_write, busy;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [9:0]  read_addr;
    logic [63:0] read_data;

    // ZERO_REG=0 instance
    logic        rst_n_nz, reg_write_nz, busy_nz;
    logic [4:0]  write_reg_nz;
    logic [31:0] write_data_nz;
    logic [9:0]  read_addr_nz;
    logic [63:0] read_data_nz;

    // NUM_RD=4, ADDR_W=3 instance
    logic         rst_n_s, reg_write_s, busy_s;
    logic [2:0]   write_reg_s;
    logic [31:0]  write_data_s;
    logic [11:0]  read_addr_s;
    logic [127:0] read_data_s;

    regfile_mp dut (
        .clk(clk), .rst_n(rst_n), .regWrite(reg_write), .writeReg(write_reg),
        .writeData(write_data), .readAddr(read_addr), .readData(read_data), .busy(busy)
    );

    regfile_mp #(.ZERO_REG(0)) dut_nz (
        .clk(clk), .rst_n(rst_n_nz), .regWrite(reg_write_nz), .writeReg(write_reg_nz),
        .writeData(write_data_nz), .readAddr(read_addr_nz), .readData(read_data_nz),
        .busy(busy_nz)
    );

    regfile_mp #(.NUM_RD(4), .ADDR_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n_s), .regWrite(reg_write_s), .writeReg(write_reg_s),
        .writeData(write_data_s), .readAddr(read_addr_s), .readData(read_data_s),
        .busy(busy_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cur_busy(input int which);
        case (which)
            0:       return busy;
            1:       return busy_nz;
            default: return busy_s;
        endcase
    endfunction

    // Counts edges until busy drops, bounded so a stuck sequencer cannot hang.
    task automatic wait_clear(input int which, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (cur_busy(which) && n < 200);
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; reg_write = 1'b0; write_reg = '0; write_data = '0; read_addr = '0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL reset_busy got=%b exp=1", busy);
        end
        checks++;
        if (read_data !== 64'h0) begin
            failures++; $display("FAIL reset_rdata got=%h exp=0", read_data);
        end
        rst_n = 1'b1;
        wait_clear(0, n);
        checks++;
        if (n != 32) begin
            failures++; $display("FAIL clear_len got=%0d exp=32", n);
        end
        for (int a = 0; a < 32; a++) begin
            read_addr = {5'(31 - a), 5'(a)};
            tick();
            checks++;
            if (read_data !== 64'h0) begin
                failures++; $display("FAIL clear_read addr=%0d got=%h exp=0", a, read_data);
            end
        end
    endtask

    task automatic test_write_read();
        reg_write = 1'b1; write_reg = 5'd7; write_data = 32'hDEADBEEF; read_addr = {5'd2, 5'd1};
        tick();
        reg_write = 1'b1; write_reg = 5'd8; write_data = 32'h11112222;
        tick();
        reg_write = 1'b0; read_addr = {5'd8, 5'd7};
        tick();
        checks++;
        if (read_data[31:0] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL write_read_r7 got=%h exp=deadbeef", read_data[31:0]);
        end
        checks++;
        if (read_data[63:32] !== 32'h11112222) begin
            failures++; $display("FAIL write_read_r8 got=%h exp=11112222", read_data[63:32]);
        end
    endtask

    task automatic test_bypass();
        reg_write = 1'b1; write_reg = 5'd5; write_data = 32'h12345678; read_addr = {5'd5, 5'd5};
        tick();
        checks++;
        if (read_data !== 64'h12345678_12345678) begin
            failures++; $display("FAIL bypass got=%h exp=1234567812345678", read_data);
        end
        reg_write = 1'b0; write_data = 32'h0;
        tick();
        checks++;
        if (read_data !== 64'h12345678_12345678) begin
            failures++; $display("FAIL bypass_stored got=%h exp=1234567812345678", read_data);
        end
    endtask

    task automatic test_zero_reg();
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF; read_addr = {5'd0, 5'd0};
        tick();
        checks++;
        if (read_data !== 64'h0) begin
            failures++; $display("FAIL zero_bypass got=%h exp=0", read_data);
        end
        reg_write = 1'b0;
        tick();
        checks++;
        if (read_data !== 64'h0) begin
            failures++; $display("FAIL zero_stored got=%h exp=0", read_data);
        end
    endtask

    task automatic test_zero_reg_off();
        int n;
        reg_write_nz = 1'b0; write_reg_nz = '0; write_data_nz = '0; read_addr_nz = '0;
        rst_n_nz = 1'b0;
        tick();
        rst_n_nz = 1'b1;
        wait_clear(1, n);
        checks++;
        if (n != 32) begin
            failures++; $display("FAIL nz_clear_len got=%0d exp=32", n);
        end
        reg_write_nz = 1'b1; write_reg_nz = 5'd0; write_data_nz = 32'hFFFFFFFF;
        read_addr_nz = {5'd0, 5'd0};
        tick();
        checks++;
        if (read_data_nz !== 64'hFFFFFFFF_FFFFFFFF) begin
            failures++; $display("FAIL nz_bypass got=%h exp=ffffffffffffffff", read_data_nz);
        end
        reg_write_nz = 1'b0;
        tick();
        checks++;
        if (read_data_nz !== 64'hFFFFFFFF_FFFFFFFF) begin
            failures++; $display("FAIL nz_stored got=%h exp=ffffffffffffffff", read_data_nz);
        end
    endtask

    task automatic test_write_during_clear();
        int n;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; reg_write = 1'b1; write_reg = 5'd3; write_data = 32'hAA; read_addr = {5'd3, 5'd3};
        repeat (5) tick();
        checks++;
        if (busy !== 1'b1 || read_data !== 64'h0) begin
            failures++; $display("FAIL clear_busy_rdata got=%b/%h exp=1/0", busy, read_data);
        end
        reg_write = 1'b0;
        wait_clear(0, n);
        checks++;
        if (n != 27) begin
            failures++; $display("FAIL clear_rest_len got=%0d exp=27", n);
        end
        tick();
        checks++;
        if (read_data[31:0] !== 32'h0) begin
            failures++; $display("FAIL write_in_clear got=%h exp=0", read_data[31:0]);
        end
    endtask

    task automatic test_first_write_at_busy_fall();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; reg_write = 1'b0; read_addr = '0;
        repeat (31) tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL busy_before_last got=%b exp=1", busy);
        end
        reg_write = 1'b1; write_reg = 5'd31; write_data = 32'h0BADF00D;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL busy_fall got=%b exp=0", busy);
        end
        reg_write = 1'b0; read_addr = {5'd31, 5'd31};
        tick();
        checks++;
        if (read_data !== 64'h0BADF00D_0BADF00D) begin
            failures++; $display("FAIL first_write got=%h exp=0badf00d0badf00d", read_data);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        reg_write = 1'b1; write_reg = 5'd9; write_data = 32'h55; read_addr = {5'd9, 5'd9};
        tick();
        reg_write = 1'b0;
        tick();
        checks++;
        if (read_data[31:0] !== 32'h55) begin
            failures++; $display("FAIL fill_r9 got=%h exp=55", read_data[31:0]);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || read_data !== 64'h0) begin
            failures++; $display("FAIL mid_reset got=%b/%h exp=1/0", busy, read_data);
        end
        rst_n = 1'b1;
        wait_clear(0, n);
        checks++;
        if (n != 32) begin
            failures++; $display("FAIL mid_clear_len got=%0d exp=32", n);
        end
        tick();
        checks++;
        if (read_data[31:0] !== 32'h0) begin
            failures++; $display("FAIL r9_after_reset got=%h exp=0", read_data[31:0]);
        end
    endtask

    task automatic test_small_ports();
        int n;
        logic [31:0] vals [4];
        vals[0] = 32'hA1A1A1A1; vals[1] = 32'hB2B2B2B2;
        vals[2] = 32'hC3C3C3C3; vals[3] = 32'hD4D4D4D4;
        reg_write_s = 1'b0; write_reg_s = '0; write_data_s = '0; read_addr_s = '0;
        rst_n_s = 1'b0;
        repeat (2) tick();
        rst_n_s = 1'b1;
        wait_clear(2, n);
        checks++;
        if (n != 8) begin
            failures++; $display("FAIL s_clear_len got=%0d exp=8", n);
        end
        for (int k = 0; k < 4; k++) begin
            reg_write_s = 1'b1; write_reg_s = 3'(k + 1); write_data_s = vals[k];
            tick();
        end
        reg_write_s = 1'b0;
        read_addr_s = {3'd4, 3'd3, 3'd2, 3'd1};
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (read_data_s[k*32 +: 32] !== vals[k]) begin
                failures++;
                $display("FAIL s_port%0d got=%h exp=%h", k, read_data_s[k*32 +: 32], vals[k]);
            end
        end
        read_addr_s = {3'd2, 3'd2, 3'd2, 3'd2};
        tick();
        checks++;
        if (read_data_s !== {4{vals[1]}}) begin
            failures++; $display("FAIL s_same_addr got=%h exp=%h", read_data_s, {4{vals[1]}});
        end
    endtask

    task automatic test_small_reset_mid();
        int n;
        reg_write_s = 1'b1; write_reg_s = 3'd5; write_data_s = 32'h55;
        read_addr_s = {3'd5, 3'd5, 3'd5, 3'd5};
        tick();
        reg_write_s = 1'b0;
        tick();
        checks++;
        if (read_data_s !== {4{32'h55}}) begin
            failures++; $display("FAIL s_fill_r5 got=%h exp=%h", read_data_s, {4{32'h55}});
        end
        rst_n_s = 1'b0;
        tick();
        rst_n_s = 1'b1;
        wait_clear(2, n);
        checks++;
        if (n != 8) begin
            failures++; $display("FAIL s_mid_clear_len got=%0d exp=8", n);
        end
        tick();
        checks++;
        if (read_data_s !== 128'h0) begin
            failures++; $display("FAIL s_r5_after_reset got=%h exp=0", read_data_s);
        end
    endtask

    initial begin
        rst_n = 1'b0; rst_n_nz = 1'b0; rst_n_s = 1'b0;
        reg_write = 1'b0; reg_write_nz = 1'b0; reg_write_s = 1'b0;
        write_reg = '0; write_reg_nz = '0; write_reg_s = '0;
        write_data = '0; write_data_nz = '0; write_data_s = '0;
        read_addr = '0; read_addr_nz = '0; read_addr_s = '0;

        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_zero_reg_off();
        test_write_during_clear();
        test_first_write_at_busy_fall();
        test_reset_mid();
        test_small_ports();
        test_small_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
